uart_rx_frame_writer: RTL

//  Receive end of the camera-to-image-processing UART link. It sits on the image-processing FPGA.
//  It deserialises 8N1 bytes from rx, LSB first, and writes them in order into the local frame buffer.

---
 rtl/uart_rx_frame_writer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_writer.sv
// rtl/uart_rx_frame_writer.sv - 8N1 UART receiver that writes one frame of bytes, in order, into a frame buffer
module uart_rx_frame_writer #(
    parameter int unsigned CLK_FREQ         = 100_000_000,
    parameter int unsigned BAUD             = 115200,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned TOTAL_BYTES      = 176*240,
    parameter int unsigned ADDR_WIDTH       = $clog2(TOTAL_BYTES),
    parameter int unsigned IDLE_TIMEOUT_CYC = CLK_FREQ/1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] wData,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic                  we,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_M1 = (DIV > 1) ? DIV - 1 : 0;
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT_CYC + 1);

    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(DIV_M1);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_BYTES - 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(IDLE_TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                  rx_meta_q, rx_s_q;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [2:0]            state_q, state_d;
    logic [3:0]            s_cnt_q, s_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Free-running oversample tick; never realigned to the start edge.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = '0;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    s_cnt_d = '0;
                end else if (byte_cnt_q != '0) begin
                    // Mid-frame silence: give up on the frame and start over at address 0.
                    if (idle_cnt_q == IDLE_LAST) begin
                        byte_cnt_d = '0;
                        err_d      = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_cnt_q == 4'd7) begin
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                        s_cnt_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rx_s_q;
                        bit_cnt_d          = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    s_cnt_d = s_cnt_q + 4'd1;
                    if (s_cnt_q == 4'd15) begin
                        s_cnt_d = '0;
                        if (rx_s_q) begin
                            // Back to IDLE at mid-stop-bit so the next start edge is never missed.
                            state_d    = S_IDLE;
                            we_d       = 1'b1;
                            wdata_d    = shift_q;
                            waddr_d    = byte_cnt_q;
                            done_d     = (byte_cnt_q == ADDR_LAST);
                            byte_cnt_d = (byte_cnt_q == ADDR_LAST) ? '0
                                                                   : byte_cnt_q + ADDR_WIDTH'(1);
                        end else begin
                            state_d = S_WAIT_HIGH;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                    s_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                s_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= S_IDLE;
            s_cnt_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wData      = wdata_q;
    assign wAddr      = waddr_q;
    assign we         = we_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (byte_cnt_q != '0);

endmodule
